// File: rtl/instr_fetch_unit.sv
// Fetch stage: owns the PC and IF/ID register, handles stall, redirect and end-of-program halt.
// Optional performance counters are built when FETCH_PERF_CNT_EN is defined.
module instr_fetch_unit #(
    parameter logic [31:0] RESET_PC = 32'd0,
    parameter logic [31:0] PC_LIMIT = 32'd84
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic [31:0] instr_in,
    output logic [31:0] read_addr,
    output logic [31:0] if_id_instr,
    output logic [31:0] if_id_pc,
    output logic        if_id_valid,
    output logic        halted,
    output logic        misalign_err,
    output logic [31:0] fetch_count,
    output logic [31:0] stall_cycles
);

    typedef enum logic [1:0] {IDLE, RUN, HALT} state_t;

    state_t      state_q;
    logic [31:0] pc_q;
    logic [31:0] instr_q;
    logic [31:0] ifid_pc_q;
    logic        valid_q;
    logic        halted_q;
    logic        misalign_q;

    logic [31:0] redirect_pc;
    logic        target_misaligned;
    logic        capture_en;

    assign redirect_pc       = {branch_target[31:2], 2'b00};
    assign target_misaligned = |branch_target[1:0];
    assign capture_en        = (state_q == RUN) && !branch_taken && !stall && (pc_q <= PC_LIMIT);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            pc_q       <= RESET_PC;
            instr_q    <= 32'd0;
            ifid_pc_q  <= 32'd0;
            valid_q    <= 1'b0;
            halted_q   <= 1'b0;
            misalign_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: state_q <= RUN;
                RUN: begin
                    if (branch_taken) begin
                        pc_q    <= redirect_pc;
                        valid_q <= 1'b0;
                        if (target_misaligned) misalign_q <= 1'b1;
                    end else if (!stall) begin
                        if (capture_en) begin
                            instr_q   <= instr_in;
                            ifid_pc_q <= pc_q;
                            valid_q   <= 1'b1;
                            pc_q      <= pc_q + 32'd4;
                        end else begin
                            valid_q  <= 1'b0;
                            halted_q <= 1'b1;
                            state_q  <= HALT;
                        end
                    end
                end
                HALT: begin
                    // A redirect out of HALT re-enters RUN; an out-of-range target halts again next edge.
                    if (branch_taken) begin
                        pc_q     <= redirect_pc;
                        valid_q  <= 1'b0;
                        halted_q <= 1'b0;
                        state_q  <= RUN;
                        if (target_misaligned) misalign_q <= 1'b1;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] fetch_cnt_q;
    logic [31:0] stall_cnt_q;
    logic        stall_count_en;

    assign stall_count_en = (state_q == RUN) && stall && !branch_taken;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            fetch_cnt_q <= 32'd0;
            stall_cnt_q <= 32'd0;
        end else begin
            if (capture_en)     fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (stall_count_en) stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign fetch_count  = fetch_cnt_q;
    assign stall_cycles = stall_cnt_q;
`else
    assign fetch_count  = 32'd0;
    assign stall_cycles = 32'd0;
`endif

    assign read_addr    = pc_q;
    assign if_id_instr  = instr_q;
    assign if_id_pc     = ifid_pc_q;
    assign if_id_valid  = valid_q;
    assign halted       = halted_q;
    assign misalign_err = misalign_q;

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed test-plan steps followed by random
// stall/redirect traffic, all compared against a behavioural fetch model.
module tb_instr_fetch_unit;

    localparam logic [31:0] LIMIT = 32'd84;
    localparam int          NWORDS = 22;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic [31:0] instr_in;
    logic [31:0] read_addr, if_id_instr, if_id_pc, fetch_count, stall_cycles;
    logic        if_id_valid, halted, misalign_err;

    logic [31:0] mem [NWORDS];

    int testsRun = 0;
    int failCount = 0;

    // Behavioural model: phase 0 = waiting after reset, 1 = fetching, 2 = halted
    int          mPhase;
    logic [31:0] mPc, mInstr, mCapPc, mFetches, mStalls;
    logic        mValid, mHalted, mMis;

    instr_fetch_unit #(.RESET_PC(32'd0), .PC_LIMIT(LIMIT)) dut (
        .clk(clk), .reset(reset), .stall(stall), .branch_taken(branch_taken),
        .branch_target(branch_target), .instr_in(instr_in), .read_addr(read_addr),
        .if_id_instr(if_id_instr), .if_id_pc(if_id_pc), .if_id_valid(if_id_valid),
        .halted(halted), .misalign_err(misalign_err), .fetch_count(fetch_count),
        .stall_cycles(stall_cycles)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] memWord(input logic [31:0] addr);
        if ((addr / 4) < NWORDS) return mem[addr / 4];
        return 32'd0;
    endfunction

    assign instr_in = memWord(read_addr);

    task automatic modelReset();
        mPhase = 0; mPc = 32'd0; mInstr = 32'd0; mCapPc = 32'd0;
        mValid = 1'b0; mHalted = 1'b0; mMis = 1'b0; mFetches = 32'd0; mStalls = 32'd0;
    endtask

    task automatic modelRedirect(input logic [31:0] tgt);
        mPc = tgt - (tgt % 4);
        if ((tgt % 4) != 0) mMis = 1'b1;
        mValid = 1'b0;
    endtask

    task automatic modelEdge(input logic st, input logic br, input logic [31:0] tgt);
        if (mPhase == 0) begin
            mPhase = 1;
        end else if (mPhase == 1) begin
            if (br) modelRedirect(tgt);
            else if (st) mStalls = mStalls + 1;
            else if (mPc > LIMIT) begin
                mValid = 1'b0; mHalted = 1'b1; mPhase = 2;
            end else begin
                mInstr = memWord(mPc); mCapPc = mPc; mValid = 1'b1;
                mPc = mPc + 4; mFetches = mFetches + 1;
            end
        end else if (br) begin
            modelRedirect(tgt);
            mHalted = 1'b0; mPhase = 1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        testsRun++;
        assert (obs === exp) else begin
            failCount++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic checkOutput(input string tag);
        logic [31:0] expFc, expSc;
`ifdef FETCH_PERF_CNT_EN
        expFc = mFetches; expSc = mStalls;
`else
        expFc = 32'd0; expSc = 32'd0;
`endif
        chk({tag, ".read_addr"}, read_addr, mPc);
        chk({tag, ".if_id_instr"}, if_id_instr, mInstr);
        chk({tag, ".if_id_pc"}, if_id_pc, mCapPc);
        chk({tag, ".if_id_valid"}, {31'd0, if_id_valid}, {31'd0, mValid});
        chk({tag, ".halted"}, {31'd0, halted}, {31'd0, mHalted});
        chk({tag, ".misalign_err"}, {31'd0, misalign_err}, {31'd0, mMis});
        chk({tag, ".fetch_count"}, fetch_count, expFc);
        chk({tag, ".stall_cycles"}, stall_cycles, expSc);
    endtask

    task automatic applyStimulus(input string tag, input logic st, input logic br,
                                 input logic [31:0] tgt);
        stall = st; branch_taken = br; branch_target = tgt;
        @(posedge clk);
        modelEdge(st, br, tgt);
        #1;
        checkOutput(tag);
    endtask

    initial begin
        for (int i = 0; i < NWORDS; i++) mem[i] = 32'h0000_0013 | (32'(i) << 20);
        mem[0]  = 32'h0000_83B3;
        mem[16] = 32'h0010_0C13;
        modelReset();

        // Reset state, checked while reset is still asserted
        #2;
        checkOutput("reset");
        #10 reset = 1'b0;

        applyStimulus("idle2run", 1'b0, 1'b0, 32'd0);
        applyStimulus("first", 1'b0, 1'b0, 32'd0);
        chk("first.pc0", if_id_pc, 32'd0);
        chk("first.instr0", if_id_instr, 32'h0000_83B3);
        chk("first.addr4", read_addr, 32'd4);

        while (mCapPc != 32'd12) applyStimulus("run", 1'b0, 1'b0, 32'd0);
        for (int i = 0; i < 3; i++) applyStimulus("stall", 1'b1, 1'b0, 32'd0);
        chk("stall.held_pc", if_id_pc, 32'd12);
        applyStimulus("post_stall", 1'b0, 1'b0, 32'd0);
        chk("post_stall.pc16", if_id_pc, 32'd16);

        while (mPc != 32'd60) applyStimulus("run", 1'b0, 1'b0, 32'd0);
        applyStimulus("br_stall", 1'b1, 1'b1, 32'd64);
        chk("br_stall.bubble", {31'd0, if_id_valid}, 32'd0);
        applyStimulus("br_target", 1'b0, 1'b0, 32'd0);
        chk("br_target.instr", if_id_instr, 32'h0010_0C13);

        for (int i = 0; i < 40 && !mHalted; i++) applyStimulus("to_end", 1'b0, 1'b0, 32'd0);
        chk("end.last_pc", if_id_pc, 32'd84);
        chk("end.halted", {31'd0, halted}, 32'd1);
        chk("end.addr88", read_addr, 32'd88);
        applyStimulus("halt_stall", 1'b1, 1'b0, 32'd0);
        applyStimulus("halt_redir", 1'b0, 1'b1, 32'd0);
        applyStimulus("restart", 1'b0, 1'b0, 32'd0);
        chk("restart.pc0", if_id_pc, 32'd0);

        applyStimulus("misalign", 1'b0, 1'b1, 32'h0000_0022);
        chk("misalign.addr", read_addr, 32'h0000_0020);
        for (int i = 0; i < 10; i++) applyStimulus("sticky", 1'b0, 1'b0, 32'd0);
        chk("sticky.err", {31'd0, misalign_err}, 32'd1);

        for (int i = 0; i < 300; i++)
            applyStimulus("random", ($urandom_range(0, 3) == 0), ($urandom_range(0, 7) == 0),
                          32'($urandom_range(0, 104)));

        for (int i = 0; i < 5; i++) applyStimulus("pre_areset", 1'b0, 1'b0, 32'd0);
        #2 reset = 1'b1;
        #1;
        modelReset();
        checkOutput("areset");
        chk("areset.fetch_count", fetch_count, 32'd0);
        #1 reset = 1'b0;
        applyStimulus("areset_idle", 1'b0, 1'b0, 32'd0);
        applyStimulus("areset_first", 1'b0, 1'b0, 32'd0);

        $display("[TB] %0d tests run, %0d failed", testsRun, failCount);
        $finish;
    end

endmodule

// File: doc/instr_fetch_unit.md
# instr_fetch_unit

Front-end fetch stage of the pipelined RV32I core: the initiator that drives `read_addr` into the combinational instruction memory and captures the returned word. It owns the program counter and the IF/ID pipeline register. It handles stall from the hazard unit, redirect from branch resolution, and end-of-program halt when the PC leaves the populated memory range.

## Interface
Parameters:
- `RESET_PC`, 32'd0: PC value loaded on reset.
- `PC_LIMIT`, 32'd84: highest valid fetch address (byte address, word-aligned).

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `reset` input 1: asynchronous, active-high.
- `stall` input 1: hold PC and IF/ID contents.
- `branch_taken` input 1: redirect request from EX.
- `branch_target` input 32: redirect address.
- `instr_in` input 32: word returned by instruction memory for `read_addr`, valid in the same cycle.
- `read_addr` output 32: current PC, driven combinationally from the PC register.
- `if_id_instr` output 32: captured instruction.
- `if_id_pc` output 32: PC of the captured instruction.
- `if_id_valid` output 1: IF/ID holds a real instruction.
- `halted` output 1: high in HALT state.
- `misalign_err` output 1: sticky; a redirect target had bits [1:0] ≠ 0.
- `fetch_count` output 32: instructions captured.
- `stall_cycles` output 32: RUN cycles with `stall`=1.

## Operation
- States: IDLE, RUN, HALT. Reset forces IDLE.
- Reset values: PC=`RESET_PC`; `if_id_instr`=0; `if_id_pc`=0; `if_id_valid`=0; `halted`=0; `misalign_err`=0; both counters=0.
- IDLE: no capture; next edge goes to RUN unconditionally. `branch_taken` is ignored in IDLE.
- RUN, priority high→low:
  - `branch_taken`:
    - PC←{`branch_target`[31:2],2'b00}; `if_id_valid`←0; stay RUN.
    - If `branch_target`[1:0]≠0, `misalign_err`←1.
    - Overrides `stall`.
  - `stall`: PC, IF/ID and `if_id_valid` hold.
  - PC > `PC_LIMIT`: no capture; `if_id_valid`←0; →HALT; PC holds.
  - Otherwise: `if_id_instr`←`instr_in`; `if_id_pc`←PC; `if_id_valid`←1; PC←PC+4 (32-bit wrap, no carry out).
- HALT:
  - `halted`=1; `if_id_valid`=0; PC holds.
  - `branch_taken` applies the redirect as in RUN and →RUN. A target still > `PC_LIMIT` returns to HALT on the following edge.
  - `stall` is ignored.
- `misalign_err` clears only on reset.
- `read_addr` always equals PC. This is a byte address; the memory indexes words at multiples of 4.

## Timing
- Fetch latency: the instruction at address A appears on `if_id_instr` one edge after `read_addr`=A.
- After reset deasserts:
  - Edge 1: IDLE→RUN.
  - Edge 2: first capture (A=`RESET_PC`).
- Throughput: one instruction per cycle while unstalled.
- Branch penalty: the edge that takes the redirect clears `if_id_valid`. The target instruction is captured on the next edge, giving one bubble.
- Stall and branch together: the branch wins, and the stall has no effect that cycle.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for a clock edge.
- Halt detection: with the limit at 84, the last capture is address 84. On the next edge PC=88, so `if_id_valid`←0 and `halted`=1 from that edge.

## Configuration
- `FETCH_PERF_CNT_EN` defined:
  - `fetch_count` increments on every capture.
  - `stall_cycles` increments on every RUN cycle with `stall`=1 and `branch_taken`=0.
  - Both counters wrap at 2^32.
- Not defined: the counter registers are not built; both ports are tied to 32'd0.

## Test plan
- Reset, run unstalled with the standard program image:
  - Edge 2 captures `if_id_pc`=0, `if_id_instr`=mem[0] (0x000083B3), valid=1.
  - Edge 3 captures PC 4; `read_addr` steps 0,4,8…
- Hold `stall` high for 3 cycles while `if_id_pc`=12 → `if_id_pc`/instr/valid unchanged for 3 edges, then PC 16 is captured. With the macro defined, `stall_cycles`=3.
- Assert `branch_taken` with target 64 together with `stall` at PC 60 → valid=0 for one edge, then `if_id_pc`=64, instr=mem[64] (addi x24).
- Run to the end → last capture `if_id_pc`=84; next edge `halted`=1, valid=0, `read_addr`=88. Redirect to 0 → RUN, capture at address 0 one edge later.
- Redirect target 0x0000_0022 → PC=0x20, `misalign_err`=1 and still 1 after 10 more cycles.
- Assert `reset` asynchronously mid-run between edges → outputs return to reset values before the next edge; `fetch_count`=0.
